// File: rtl/softmax_driver.sv
// softmax_driver: packs a valid/ready stream into a softmax request,
// runs the active-low level handshake and replays the result vector.
module softmax_driver #(
  parameter int DATA_WIDTH     = 8,
  parameter int INPUT_NUM      = 10,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                            clk_p,
  input  logic                            rst_n,
  input  logic [DATA_WIDTH-1:0]           in_data,
  input  logic                            in_valid,
  output logic                            in_ready,
  output logic [DATA_WIDTH*INPUT_NUM-1:0] sm_inputs,
  output logic                            sm_input_valid_n,
  input  logic [DATA_WIDTH*INPUT_NUM-1:0] sm_outputs,
  input  logic                            sm_output_valid_n,
  output logic [DATA_WIDTH-1:0]           out_data,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic                            out_last,
  output logic                            busy,
  output logic                            timeout_err,
  input  logic                            err_clr
);

  localparam int VW = DATA_WIDTH * INPUT_NUM;
  localparam int CW = $clog2(INPUT_NUM);
  localparam logic [CW-1:0] LAST = CW'(INPUT_NUM - 1);
  localparam bit TMO_EN = (TIMEOUT_CYCLES != 0);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    FILL,
    REQ,
    DRAIN,
    GAP
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   fill_q, fill_d;
  logic [CW-1:0]   drain_q, drain_d;
  logic [15:0]     tmo_q, tmo_d;
  logic            gap_q, gap_d;
  logic [VW-1:0]   vec_q, vec_d;
  logic [VW-1:0]   res_q, res_d;
  logic            err_q, err_d;
  logic            err_set;
  logic            en_q;

  // State, counters, vector/result registers and the sticky error
  always_ff @(posedge clk_p or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= FILL;
      fill_q  <= '0;
      drain_q <= '0;
      tmo_q   <= '0;
      gap_q   <= 1'b0;
      vec_q   <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
      en_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      drain_q <= drain_d;
      tmo_q   <= tmo_d;
      gap_q   <= gap_d;
      vec_q   <= vec_d;
      res_q   <= res_d;
      err_q   <= err_d;
      en_q    <= 1'b1;
    end
  end

  // Next-state: fill slots, wait for ack or timeout, drain, settle gap
  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    drain_d = drain_q;
    tmo_d   = tmo_q;
    gap_d   = gap_q;
    vec_d   = vec_q;
    res_d   = res_q;
    err_set = 1'b0;
    unique case (state_q)
      FILL: begin
        if (in_valid && en_q) begin
          vec_d[DATA_WIDTH*fill_q +: DATA_WIDTH] = in_data;
          if (fill_q == LAST) begin
            fill_d  = '0;
            tmo_d   = '0;
            state_d = REQ;
          end else begin
            fill_d = fill_q + 1'b1;
          end
        end
      end
      REQ: begin
        tmo_d = tmo_q + 16'd1;
        if (!sm_output_valid_n) begin
          res_d   = sm_outputs;
          drain_d = '0;
          state_d = DRAIN;
        end else if (TMO_EN && tmo_q == TMO_LAST) begin
          err_set = 1'b1;
          vec_d   = '0;
          gap_d   = 1'b0;
          state_d = GAP;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (drain_q == LAST) begin
            drain_d = '0;
            state_d = FILL;
          end else begin
            drain_d = drain_q + 1'b1;
          end
        end
      end
      GAP: begin
        if (gap_q) begin
          gap_d   = 1'b0;
          state_d = FILL;
        end else begin
          gap_d = 1'b1;
        end
      end
    endcase
  end

  // A fresh timeout beats a simultaneous clear
  always_comb begin
    err_d = err_q;
    if (err_set) begin
      err_d = 1'b1;
    end else if (err_clr) begin
      err_d = 1'b0;
    end
  end

  // Outputs decoded from state; in_ready waits one edge after reset
  always_comb begin
    in_ready         = en_q && (state_q == FILL);
    sm_input_valid_n = (state_q != REQ);
    sm_inputs        = vec_q;
    out_valid        = (state_q == DRAIN);
    out_data         = '0;
    if (out_valid) begin
      out_data = res_q[DATA_WIDTH*drain_q +: DATA_WIDTH];
    end
    out_last    = out_valid && (drain_q == LAST);
    busy        = (state_q != FILL);
    timeout_err = err_q;
  end

endmodule
